// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and decode helpers for the data-memory responder.
package dmem_pkg;
    localparam int TAG_W_MAX = 16;
    localparam int CD_W = 4;
    typedef enum logic [1:0] {OP_NONE, OP_WR, OP_RD, OP_MAINT} op_e;
    typedef struct packed {
        logic [TAG_W_MAX-1:0] tag;
        logic [31:0]          data;
        logic                 error;
        logic [CD_W-1:0]      countdown;
    } resp_entry_t;
    function automatic op_e decode_op(input logic rd, input logic [3:0] wr, input logic maint);
        return (|wr) ? OP_WR : rd ? OP_RD : maint ? OP_MAINT : OP_NONE;
    endfunction
    // Only reads and writes can fault; maintenance ops never touch the array.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned words, input logic rw);
        return rw && (({2'b00, addr} >= (34'(words) << 2)) || (addr[1:0] != 2'b00));
    endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: mem_d_* request/response channel between core and data memory.
interface dmem_responder_if #(
    parameter int TAG_W = 11
);
    logic [31:0]      mem_d_addr_w;
    logic [31:0]      mem_d_data_wr_w;
    logic             mem_d_rd_w;
    logic [3:0]       mem_d_wr_w;
    logic             mem_d_cacheable_w;
    logic [TAG_W-1:0] mem_d_req_tag_w;
    logic             mem_d_invalidate_w;
    logic             mem_d_writeback_w;
    logic             mem_d_flush_w;
    logic             mem_d_accept_w;
    logic             mem_d_ack_w;
    logic [31:0]      mem_d_data_rd_w;
    logic             mem_d_error_w;
    logic [TAG_W-1:0] mem_d_resp_tag_w;
    modport master (
        output mem_d_addr_w, mem_d_data_wr_w, mem_d_rd_w, mem_d_wr_w, mem_d_cacheable_w,
               mem_d_req_tag_w, mem_d_invalidate_w, mem_d_writeback_w, mem_d_flush_w,
        input  mem_d_accept_w, mem_d_ack_w, mem_d_data_rd_w, mem_d_error_w, mem_d_resp_tag_w
    );
    modport slave (
        input  mem_d_addr_w, mem_d_data_wr_w, mem_d_rd_w, mem_d_wr_w, mem_d_cacheable_w,
               mem_d_req_tag_w, mem_d_invalidate_w, mem_d_writeback_w, mem_d_flush_w,
        output mem_d_accept_w, mem_d_ack_w, mem_d_data_rd_w, mem_d_error_w, mem_d_resp_tag_w
    );
endinterface

// File: rtl/dmem_resp_fifo.sv
// dmem_resp_fifo: in-order response queue; the head pops once its countdown reaches zero.
module dmem_resp_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  resp_entry_t            entry_i,
    output resp_entry_t            head_o,
    output logic                   head_rdy_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    resp_entry_t   ent_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop;
    always_comb begin
        head_o     = ent_q[rptr_q];
        empty_o    = cnt_q == '0;
        full_o     = cnt_q == CW'(DEPTH);
        pop        = !empty_o && head_o.countdown == '0;
        head_rdy_o = pop;
        count_o    = cnt_q;
        wptr_d     = wptr_q + PW'(push_i);
        rptr_d     = rptr_q + PW'(pop);
        cnt_d      = cnt_q + CW'(push_i) - CW'(pop);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    // Every slot counts down independently, so a blocked entry is ready the moment it reaches the head.
    always_ff @(posedge clk)
        for (int i = 0; i < DEPTH; i++)
            if (push_i && wptr_q == PW'(i)) ent_q[i] <= entry_i;
            else if (ent_q[i].countdown != '0) ent_q[i].countdown <= ent_q[i].countdown - CD_W'(1);
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-array data memory slave with byte strobes, tagged in-order acks and
// programmable latency.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS   = 16384,
    parameter int LATENCY     = 2,
    parameter int QUEUE_DEPTH = 4,
    parameter int TAG_W       = 11
) (
    input logic              clk,
    input logic              rst_n,
    dmem_responder_if.slave  bus
);
    localparam int AW = $clog2(MEM_WORDS);
    logic [31:0]                  mem_q [MEM_WORDS];
    logic [AW-1:0]                idx;
    logic                         maint, valid, err, accept, fire, full, empty, head_rdy;
    logic [$clog2(QUEUE_DEPTH):0] count;
    op_e                          op;
    resp_entry_t                  push_entry, head;
    logic                         unused_ok;
    always_comb begin
        maint      = bus.mem_d_invalidate_w | bus.mem_d_writeback_w | bus.mem_d_flush_w;
        valid      = bus.mem_d_rd_w | (|bus.mem_d_wr_w) | maint;
        op         = decode_op(bus.mem_d_rd_w, bus.mem_d_wr_w, maint);
        idx        = bus.mem_d_addr_w[AW+1:2];
        err        = addr_err(bus.mem_d_addr_w, MEM_WORDS, op == OP_WR || op == OP_RD);
        accept     = rst_n && !full;
        fire       = valid && accept;
        push_entry = '{tag: TAG_W_MAX'(bus.mem_d_req_tag_w),
                       data: (op == OP_RD && !err) ? mem_q[idx] : '0,
                       error: err,
                       countdown: CD_W'(LATENCY - 1)};
    end
    // Reads sample the array before this edge's write, so a read sees every earlier accepted write.
    always_ff @(posedge clk)
        if (fire && op == OP_WR && !err)
            for (int b = 0; b < 4; b++)
                if (bus.mem_d_wr_w[b]) mem_q[idx][8*b +: 8] <= bus.mem_d_data_wr_w[8*b +: 8];
    dmem_resp_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (fire),
        .entry_i    (push_entry),
        .head_o     (head),
        .head_rdy_o (head_rdy),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count)
    );
    assign bus.mem_d_accept_w   = accept;
    assign bus.mem_d_ack_w      = head_rdy;
    assign bus.mem_d_data_rd_w  = head_rdy ? head.data : '0;
    assign bus.mem_d_error_w    = head_rdy && head.error;
    assign bus.mem_d_resp_tag_w = head_rdy ? TAG_W'(head.tag) : '0;
    assign unused_ok            = ^{bus.mem_d_cacheable_w, empty, count, head};
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed table, back-to-back, reset and random traffic against a
// queue-based reference model of the responder.
module tb_dmem_responder;
    localparam int MW = 256, LAT = 4, QD = 4, TW = 11;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    dmem_responder_if #(.TAG_W(TW)) bus ();
    dmem_responder #(.MEM_WORDS(MW), .LATENCY(LAT), .QUEUE_DEPTH(QD), .TAG_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    typedef struct {
        logic          rd;
        logic [3:0]    wr;
        logic [2:0]    mnt;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [TW-1:0] tag;
        logic [31:0]   exp_data;
        logic          exp_err;
    } vec_t;
    typedef struct {
        logic [TW-1:0] tag;
        logic [31:0]   data;
        logic          err;
        int            due;
    } exp_t;
    logic [31:0]   ref_mem [MW];
    exp_t          mq[$];
    logic [TW-1:0] ack_tag_log[$];
    int            ack_cyc_log[$];
    int            cyc = 0, last_due = 0, n_cmp = 0, n_fail = 0;
    logic          dut_acc;
    logic [31:0]   got_data;
    logic          got_err;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.mem_d_rd_w         = v.rd;
        bus.mem_d_wr_w         = v.wr;
        bus.mem_d_invalidate_w = v.mnt[2];
        bus.mem_d_writeback_w  = v.mnt[1];
        bus.mem_d_flush_w      = v.mnt[0];
        bus.mem_d_addr_w       = v.addr;
        bus.mem_d_data_wr_w    = v.wdata;
        bus.mem_d_req_tag_w    = v.tag;
        bus.mem_d_cacheable_w  = 1'($urandom_range(0, 1));
    endtask

    task automatic idle();
        bus.mem_d_rd_w         = 1'b0;
        bus.mem_d_wr_w         = 4'h0;
        bus.mem_d_invalidate_w = 1'b0;
        bus.mem_d_writeback_w  = 1'b0;
        bus.mem_d_flush_w      = 1'b0;
        bus.mem_d_addr_w       = 32'h0;
        bus.mem_d_data_wr_w    = 32'h0;
        bus.mem_d_req_tag_w    = '0;
        bus.mem_d_cacheable_w  = 1'b0;
    endtask

    // One clock: compare outputs mid-cycle against the model, then advance the model.
    task automatic cycle();
        logic exp_acc, exp_ack, v, is_wr, is_rd, e;
        int   w;
        exp_t n;
        @(negedge clk);
        exp_acc = rst_n && (mq.size() < QD);
        exp_ack = rst_n && mq.size() != 0 && mq[0].due == cyc;
        chk("accept", 32'(bus.mem_d_accept_w), 32'(exp_acc));
        chk("ack", 32'(bus.mem_d_ack_w), 32'(exp_ack));
        if (exp_ack) begin
            chk("data", bus.mem_d_data_rd_w, mq[0].data);
            chk("error", 32'(bus.mem_d_error_w), 32'(mq[0].err));
            chk("resp_tag", 32'(bus.mem_d_resp_tag_w), 32'(mq[0].tag));
            void'(mq.pop_front());
        end
        if (!rst_n) begin
            chk("rst_data", bus.mem_d_data_rd_w, 32'h0);
            chk("rst_error", 32'(bus.mem_d_error_w), 32'h0);
            chk("rst_tag", 32'(bus.mem_d_resp_tag_w), 32'h0);
        end
        if (bus.mem_d_ack_w) begin
            ack_tag_log.push_back(bus.mem_d_resp_tag_w);
            ack_cyc_log.push_back(cyc);
            got_data = bus.mem_d_data_rd_w;
            got_err  = bus.mem_d_error_w;
        end
        dut_acc = bus.mem_d_accept_w;
        v = bus.mem_d_rd_w || bus.mem_d_wr_w != 0 || bus.mem_d_invalidate_w ||
            bus.mem_d_writeback_w || bus.mem_d_flush_w;
        if (v && exp_acc) begin
            is_wr = bus.mem_d_wr_w != 0;
            is_rd = !is_wr && bus.mem_d_rd_w;
            e     = (is_wr || is_rd) && (bus.mem_d_addr_w >= MW * 4 || bus.mem_d_addr_w[1:0] != 2'b00);
            w     = int'(bus.mem_d_addr_w >> 2);
            n.tag  = bus.mem_d_req_tag_w;
            n.data = (is_rd && !e) ? ref_mem[w] : 32'h0;
            n.err  = e;
            n.due  = (cyc + LAT > last_due + 1) ? cyc + LAT : last_due + 1;
            last_due = n.due;
            if (is_wr && !e)
                for (int b = 0; b < 4; b++)
                    if (bus.mem_d_wr_w[b]) ref_mem[w][8*b +: 8] = bus.mem_d_data_wr_w[8*b +: 8];
            mq.push_back(n);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input vec_t v, output int ac);
        drive(v);
        ac = -1;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (dut_acc) begin
                ac = cyc - 1;
                break;
            end
        end
        chk("accept_timeout", 32'(ac >= 0), 32'h1);
        idle();
    endtask

    task automatic wait_acks(input int n0, input int want);
        for (int k = 0; k < 60 && ack_tag_log.size() < n0 + want; k++) cycle();
        chk("ack_timeout", 32'(ack_tag_log.size() >= n0 + want), 32'h1);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && mq.size() != 0; k++) cycle();
        chk("drain_timeout", 32'(mq.size()), 32'h0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [17];
        vec_t v;
        int   ac, n0;
        int   acs [5];
        tbl = '{
            '{1'b0, 4'hF, 3'b000, 32'h100, 32'hDEADBEEF, 11'h005, 32'h0, 1'b0},
            '{1'b1, 4'h0, 3'b000, 32'h100, 32'h0, 11'h006, 32'hDEADBEEF, 1'b0},
            '{1'b0, 4'h1, 3'b000, 32'h100, 32'h000000AA, 11'h007, 32'h0, 1'b0},
            '{1'b1, 4'h0, 3'b000, 32'h100, 32'h0, 11'h008, 32'hDEADBEAA, 1'b0},
            '{1'b1, 4'h0, 3'b000, 32'h102, 32'h0, 11'h009, 32'h0, 1'b1},
            '{1'b1, 4'h0, 3'b000, 32'h400, 32'h0, 11'h00A, 32'h0, 1'b1},
            '{1'b0, 4'hF, 3'b000, 32'h102, 32'h11111111, 11'h00B, 32'h0, 1'b1},
            '{1'b0, 4'hF, 3'b000, 32'h400, 32'h22222222, 11'h00C, 32'h0, 1'b1},
            '{1'b1, 4'h0, 3'b000, 32'h100, 32'h0, 11'h00D, 32'hDEADBEAA, 1'b0},
            '{1'b0, 4'h0, 3'b001, 32'h000, 32'h0, 11'h7FF, 32'h0, 1'b0},
            '{1'b1, 4'hF, 3'b000, 32'h104, 32'h12345678, 11'h010, 32'h0, 1'b0},
            '{1'b1, 4'h0, 3'b000, 32'h104, 32'h0, 11'h011, 32'h12345678, 1'b0},
            '{1'b0, 4'h0, 3'b100, 32'h403, 32'h0, 11'h012, 32'h0, 1'b0},
            '{1'b0, 4'hF, 3'b000, 32'h3FC, 32'hCAFEF00D, 11'h014, 32'h0, 1'b0},
            '{1'b1, 4'h0, 3'b000, 32'h3FC, 32'h0, 11'h015, 32'hCAFEF00D, 1'b0},
            '{1'b0, 4'h6, 3'b000, 32'h3FC, 32'h00123400, 11'h016, 32'h0, 1'b0},
            '{1'b1, 4'h0, 3'b010, 32'h3FC, 32'h0, 11'h017, 32'hCA12340D, 1'b0}
        };
        idle();
        for (int i = 0; i < 2; i++) cycle();
        rst_n = 1'b1;
        cycle();
        // Give every word a known value so partial-strobe writes are fully predictable.
        for (int i = 0; i < MW; i++) begin
            v = '{1'b0, 4'hF, 3'b000, 32'(i * 4), $urandom, TW'(i), 32'h0, 1'b0};
            issue(v, ac);
        end
        drain();
        for (int i = 0; i < 17; i++) begin
            n0 = ack_tag_log.size();
            issue(tbl[i], ac);
            wait_acks(n0, 1);
            if (ack_tag_log.size() > n0) begin
                chk($sformatf("vec%0d_tag", i), 32'(ack_tag_log[n0]), 32'(tbl[i].tag));
                chk($sformatf("vec%0d_data", i), got_data, tbl[i].exp_data);
                chk($sformatf("vec%0d_err", i), 32'(got_err), 32'(tbl[i].exp_err));
                chk($sformatf("vec%0d_latency", i), 32'(ack_cyc_log[n0] - ac), 32'(LAT));
            end
        end
        drain();
        n0 = ack_tag_log.size();
        for (int i = 0; i < 5; i++) begin
            v = '{1'b1, 4'h0, 3'b000, 32'h100, 32'h0, TW'(i + 1), 32'h0, 1'b0};
            issue(v, acs[i]);
        end
        for (int i = 1; i < 4; i++) chk($sformatf("b2b_accept%0d", i), 32'(acs[i] - acs[0]), 32'(i));
        chk("b2b_accept_after_pop", 32'(acs[4] - acs[0]), 32'(LAT + 1));
        wait_acks(n0, 5);
        if (ack_tag_log.size() >= n0 + 5) begin
            for (int i = 0; i < 5; i++) chk($sformatf("b2b_tag%0d", i), 32'(ack_tag_log[n0 + i]), 32'(i + 1));
            chk("b2b_last_ack_cycle", 32'(ack_cyc_log[n0 + 4] - acs[0]), 32'(2 * LAT + 1));
        end
        drain();
        v = '{1'b1, 4'h0, 3'b000, 32'h104, 32'h0, 11'h020, 32'h0, 1'b0};
        issue(v, ac);
        v = '{1'b1, 4'h0, 3'b000, 32'h100, 32'h0, 11'h021, 32'h0, 1'b0};
        issue(v, ac);
        v = '{1'b1, 4'h0, 3'b000, 32'h3FC, 32'h0, 11'h022, 32'h0, 1'b0};
        issue(v, ac);
        rst_n = 1'b0;
        mq.delete();
        last_due = 0;
        n0 = ack_tag_log.size();
        v = '{1'b0, 4'hF, 3'b000, 32'h104, 32'hFFFFFFFF, 11'h023, 32'h0, 1'b0};
        drive(v);
        for (int i = 0; i < 3; i++) cycle();
        idle();
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 4; i++) cycle();
        chk("reset_discards_acks", 32'(ack_tag_log.size()), 32'(n0));
        v = '{1'b1, 4'h0, 3'b000, 32'h104, 32'h0, 11'h024, 32'h0, 1'b0};
        issue(v, ac);
        wait_acks(n0, 1);
        chk("reset_keeps_memory", got_data, 32'h12345678);
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            v.addr  = $urandom_range(0, MW * 4 + 15);
            if ($urandom_range(0, 3) != 0) v.addr[1:0] = 2'b00;
            v.wdata = $urandom;
            v.tag   = TW'($urandom);
            v.rd    = r < 4 || (r < 8 && $urandom_range(0, 1) == 1) || (r == 9);
            v.wr    = (r >= 4 && r < 8) ? 4'($urandom_range(1, 15)) : 4'h0;
            v.mnt   = (r >= 8) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
            issue(v, ac);
            for (int g = int'($urandom_range(0, 3)); g > 2; g--) cycle();
        end
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
